alu_branch_seq: RTL and testbench

//  Multi-cycle requester for the core's combinational ALU. Takes one conditional-branch request per transaction
//  and drives the ALU's input_a/input_b/alu_control. Compares rs1/rs2 by SUB and reads the returned flags
//  {N,Z,C,V}. Then reuses the ALU as an adder to form the next-PC target. Sits between decode and fetch redirect.

---
 rtl/alu_branch_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_branch_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_branch_seq.sv
// Branch resolution sequencer: drives a shared combinational ALU to compare rs1/rs2 with a SUB,
// then reuses it as an adder for the redirect target, and returns one response per request.
module alu_branch_seq #(
   parameter bit NT_TARGET_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [31:0] req_pc,
   input  logic [31:0] req_imm,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_control,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_taken,
   output logic [31:0] rsp_target,
   output logic        rsp_illegal
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      TGT  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   state_e      state_q, state_d;

   logic [2:0]  funct3_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;
   logic [31:0] pc_q;
   logic [31:0] imm_q;

   logic        valid_q, valid_d;
   logic        taken_q, taken_d;
   logic        illegal_q, illegal_d;
   logic [31:0] target_q, target_d;

   logic        accept;
   logic        flag_n, flag_z, flag_c, flag_v;
   logic        cond_taken;
   logic        cond_illegal;

   assign req_ready   = (state_q == IDLE) && !flush;
   assign accept      = req_valid && req_ready;

   assign {flag_n, flag_z, flag_c, flag_v} = alu_flags;

   assign rsp_valid   = valid_q;
   assign rsp_taken   = taken_q;
   assign rsp_target  = target_q;
   assign rsp_illegal = illegal_q;

   // Branch condition from the SUB flags of the latched operands; C is the unsigned borrow.
   always_comb begin
      cond_taken   = 1'b0;
      cond_illegal = 1'b0;
      case (funct3_q)
         F3_BEQ:  cond_taken = flag_z;
         F3_BNE:  cond_taken = !flag_z;
         F3_BLT:  cond_taken = flag_n ^ flag_v;
         F3_BGE:  cond_taken = !(flag_n ^ flag_v);
         F3_BLTU: cond_taken = flag_c;
         F3_BGEU: cond_taken = !flag_c;
         default: cond_illegal = 1'b1;
      endcase
   end

   // NOTE: every signal assigned in this block gets a default first, so no path can leave one
   // unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      taken_d     = taken_q;
      illegal_d   = illegal_q;
      target_d    = target_q;
      alu_a       = 32'd0;
      alu_b       = 32'd0;
      alu_control = ALU_ADD;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = CMP;
            end
         end

         CMP: begin
            alu_a       = rs1_q;
            alu_b       = rs2_q;
            alu_control = ALU_SUB;
            if (cond_illegal) begin
               illegal_d = 1'b1;
               taken_d   = 1'b0;
               target_d  = 32'd0;
               valid_d   = 1'b1;
               state_d   = DONE;
            end else begin
               illegal_d = 1'b0;
               taken_d   = cond_taken;
               if (cond_taken || NT_TARGET_EN) begin
                  state_d = TGT;
               end else begin
                  target_d = 32'd0;
                  valid_d  = 1'b1;
                  state_d  = DONE;
               end
            end
         end

         TGT: begin
            // Target wraps modulo 2^32; the adder's carry/overflow flags are ignored here.
            alu_a       = pc_q;
            alu_b       = taken_q ? imm_q : 32'd4;
            alu_control = ALU_ADD;
            target_d    = alu_result;
            valid_d     = 1'b1;
            state_d     = DONE;
         end

         DONE: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      if (flush) begin
         valid_d = 1'b0;
         state_d = IDLE;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
         target_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         taken_q   <= taken_d;
         illegal_q <= illegal_d;
         target_q  <= target_d;
      end
   end

   // NOTE: operand registers carry no reset; they are only read after an accept has loaded them,
   // so resetting them would add reset fan-out without changing behaviour.
   always_ff @(posedge clk) begin
      if (accept) begin
         funct3_q <= req_funct3;
         rs1_q    <= req_rs1;
         rs2_q    <= req_rs2;
         pc_q     <= req_pc;
         imm_q    <= req_imm;
      end
   end

endmodule

// File: tb/tb_alu_branch_seq.sv
// Directed bench for alu_branch_seq: two instances (NT_TARGET_EN=1 and 0), each with its own
// behavioural ALU, checked with immediate assertions against hand-computed results.
module tb_alu_branch_seq;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1, req_rs2, req_pc, req_imm;

   logic        req_valid0, req_ready0, rsp_ready0, rsp_valid0, rsp_taken0, rsp_illegal0;
   logic [31:0] alu_a0, alu_b0, alu_result0, rsp_target0;
   logic [2:0]  alu_control0;
   logic [3:0]  alu_flags0;

   logic        req_valid1, req_ready1, rsp_ready1, rsp_valid1, rsp_taken1, rsp_illegal1;
   logic [31:0] alu_a1, alu_b1, alu_result1, rsp_target1;
   logic [2:0]  alu_control1;
   logic [3:0]  alu_flags1;

   int n_tests = 0;
   int n_fail  = 0;

   alu_branch_seq #(.NT_TARGET_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_funct3(req_funct3),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc), .req_imm(req_imm),
      .alu_a(alu_a0), .alu_b(alu_b0), .alu_control(alu_control0),
      .alu_result(alu_result0), .alu_flags(alu_flags0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_taken(rsp_taken0),
      .rsp_target(rsp_target0), .rsp_illegal(rsp_illegal0)
   );

   alu_branch_seq #(.NT_TARGET_EN(1'b0)) u_dut_nt (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_funct3(req_funct3),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc), .req_imm(req_imm),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_control(alu_control1),
      .alu_result(alu_result1), .alu_flags(alu_flags1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_taken(rsp_taken1),
      .rsp_target(rsp_target1), .rsp_illegal(rsp_illegal1)
   );

   // Reference ALU: returns {N,Z,C,V,result}; C on SUB is the unsigned borrow.
   function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] ctl);
      logic [32:0] full;
      logic [31:0] r;
      logic        v;
      if (ctl == 3'b001) begin
         full = {1'b0, a} - {1'b0, b};
         r    = full[31:0];
         v    = (a[31] != b[31]) && (r[31] != a[31]);
      end else begin
         full = {1'b0, a} + {1'b0, b};
         r    = full[31:0];
         v    = (a[31] == b[31]) && (r[31] != a[31]);
      end
      return {r[31], (r == 32'd0), full[32], v, r};
   endfunction

   always_comb {alu_flags0, alu_result0} = alu_model(alu_a0, alu_b0, alu_control0);
   always_comb {alu_flags1, alu_result1} = alu_model(alu_a1, alu_b1, alu_control1);

   // Selected-instance view so one set of tasks serves both DUTs.
   bit          sel;
   logic        s_ready, s_valid, s_taken, s_illegal;
   logic [31:0] s_target, s_a, s_b;
   logic [2:0]  s_ctl;
   always_comb begin
      s_ready   = sel ? req_ready1   : req_ready0;
      s_valid   = sel ? rsp_valid1   : rsp_valid0;
      s_taken   = sel ? rsp_taken1   : rsp_taken0;
      s_illegal = sel ? rsp_illegal1 : rsp_illegal0;
      s_target  = sel ? rsp_target1  : rsp_target0;
      s_a       = sel ? alu_a1       : alu_a0;
      s_b       = sel ? alu_b1       : alu_b0;
      s_ctl     = sel ? alu_control1 : alu_control0;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_valid(input logic v);
      if (sel) req_valid1 = v;
      else     req_valid0 = v;
   endtask

   task automatic set_rsp_ready(input logic v);
      if (sel) rsp_ready1 = v;
      else     rsp_ready0 = v;
   endtask

   // Issue one branch and check ALU drive, latency, response fields, hold and handshake.
   task automatic run_branch(input bit dut, input string name, input logic [2:0] f3,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input int exp_lat, input logic exp_taken,
                             input logic [31:0] exp_tgt, input logic exp_ill,
                             input int hold, input bit flush_on_hs);
      int cyc;
      sel = dut;
      @(negedge clk);
      req_funct3 = f3;
      req_rs1    = rs1;
      req_rs2    = rs2;
      req_pc     = pc;
      req_imm    = imm;
      set_valid(1'b1);
      #1 check({name, " req_ready"}, 32'(s_ready), 32'd1);
      next_cycle();
      set_valid(1'b0);
      req_rs1 = ~rs1;
      req_rs2 = ~rs2;
      req_pc  = ~pc;
      req_imm = ~imm;
      #1;
      check({name, " cmp ctl"}, 32'(s_ctl), 32'd1);
      check({name, " cmp a"},   s_a, rs1);
      check({name, " cmp b"},   s_b, rs2);
      cyc = 1;
      while (!s_valid && cyc < 8) begin
         if (cyc == 2) begin
            check({name, " tgt ctl"}, 32'(s_ctl), 32'd0);
            check({name, " tgt a"},   s_a, pc);
            check({name, " tgt b"},   s_b, exp_taken ? imm : 32'd4);
         end
         next_cycle();
         #1;
         cyc++;
      end
      check({name, " latency"}, 32'(cyc), 32'(exp_lat));
      check({name, " rsp"}, {28'd0, s_valid, s_taken, s_illegal, 1'b0}, {28'd0, 1'b1, exp_taken, exp_ill, 1'b0});
      check({name, " target"}, s_target, exp_tgt);
      for (int i = 0; i < hold; i++) begin
         next_cycle();
         #1;
         check({name, " hold flags"}, {28'd0, s_valid, s_taken, s_illegal, s_ready}, {28'd0, 1'b1, exp_taken, exp_ill, 1'b0});
         check({name, " hold target"}, s_target, exp_tgt);
      end
      // Handshake cycle: a new request must not be accepted in DONE.
      set_rsp_ready(1'b1);
      set_valid(1'b1);
      if (flush_on_hs) flush = 1'b1;
      #1 check({name, " no accept in DONE"}, 32'(s_ready), 32'd0);
      next_cycle();
      set_rsp_ready(1'b0);
      set_valid(1'b0);
      flush = 1'b0;
      #1;
      check({name, " after hs"}, {30'd0, s_valid, s_ready}, {30'd0, 1'b0, 1'b1});
   endtask

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      sel        = 1'b0;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      rsp_ready0 = 1'b0;
      rsp_ready1 = 1'b0;
      req_funct3 = 3'b000;
      req_rs1    = 32'd0;
      req_rs2    = 32'd0;
      req_pc     = 32'd0;
      req_imm    = 32'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset rsp", {28'd0, rsp_valid0, rsp_taken0, rsp_illegal0, req_ready0}, 32'd1);
      check("reset target", rsp_target0, 32'd0);
      check("reset idle alu", {alu_a0 | alu_b0}, 32'd0);
      check("reset idle ctl", 32'(alu_control0), 32'd0);
      rst = 1'b0;

      run_branch(1'b0, "BEQ",  3'b000, 32'd5,        32'd5, 32'h100,      32'h20, 3, 1'b1, 32'h120,      1'b0, 0, 1'b0);
      run_branch(1'b0, "BLT",  3'b100, 32'hFFFFFFFF, 32'd1, 32'h200,      32'h10, 3, 1'b1, 32'h210,      1'b0, 5, 1'b0);
      run_branch(1'b0, "BLTU", 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200,      32'h10, 3, 1'b0, 32'h204,      1'b0, 0, 1'b0);
      run_branch(1'b0, "BGE",  3'b101, 32'h80000000, 32'd1, 32'h300,      32'h40, 3, 1'b0, 32'h304,      1'b0, 0, 1'b0);
      run_branch(1'b0, "BGEU", 3'b111, 32'h80000000, 32'd1, 32'h300,      32'h40, 3, 1'b1, 32'h340,      1'b0, 0, 1'b0);
      run_branch(1'b0, "BNE",  3'b001, 32'd1,        32'd2, 32'hFFFFFFF8, 32'h10, 3, 1'b1, 32'h00000008, 1'b0, 1, 1'b1);
      run_branch(1'b0, "ILL",  3'b010, 32'd7,        32'd7, 32'h500,      32'h10, 2, 1'b0, 32'h0,        1'b1, 0, 1'b0);
      run_branch(1'b1, "NT0 BEQ", 3'b000, 32'd1,     32'd2, 32'h400,      32'h8,  2, 1'b0, 32'h0,        1'b0, 0, 1'b0);
      run_branch(1'b1, "NT0 BNE", 3'b001, 32'd1,     32'd2, 32'h400,      32'h8,  3, 1'b1, 32'h408,      1'b0, 0, 1'b0);

      // Flush while in TGT: transaction dropped, no response, ready again next cycle.
      sel = 1'b0;
      @(negedge clk);
      req_funct3 = 3'b000;
      req_rs1    = 32'd5;
      req_rs2    = 32'd5;
      req_pc     = 32'h600;
      req_imm    = 32'h20;
      req_valid0 = 1'b1;
      next_cycle();
      req_valid0 = 1'b0;
      next_cycle();
      #1 check("flush tgt ctl", 32'(alu_control0), 32'd0);
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      #1 check("flush ready", {30'd0, rsp_valid0, req_ready0}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #1 check("flush no rsp", {30'd0, rsp_valid0, req_ready0}, 32'd1);
      end

      // Flush in IDLE with a valid request: not accepted.
      req_valid0 = 1'b1;
      flush      = 1'b1;
      #1 check("idle flush ready", 32'(req_ready0), 32'd0);
      next_cycle();
      req_valid0 = 1'b0;
      flush      = 1'b0;
      #1 check("idle flush not accepted", 32'(req_ready0), 32'd1);
      next_cycle();
      next_cycle();
      #1 check("idle flush no rsp", {30'd0, rsp_valid0, req_ready0}, 32'd1);

      // Reset in CMP: dropped, registered outputs cleared.
      req_funct3 = 3'b001;
      req_rs1    = 32'd1;
      req_rs2    = 32'd2;
      req_valid0 = 1'b1;
      next_cycle();
      req_valid0 = 1'b0;
      rst        = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1 check("rst mid flags", {28'd0, rsp_valid0, rsp_taken0, rsp_illegal0, req_ready0}, 32'd1);
      check("rst mid target", rsp_target0, 32'd0);
      next_cycle();
      next_cycle();
      #1 check("rst mid no rsp", 32'(rsp_valid0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
